multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Control FSM that converts the core into a multi-cycle machine sharing one memory port between instruction fetch and load/store.
- Sequences fetch, decode, execute, memory and writeback phases.
- Latches the 6-bit control-store address from the address decoder once branch compare flags are stable.
- Drives pc/IR/register-file enables and a retired-instruction counter.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter.
- UADDR_W, 6, width of control-store address from the decoder.
- TIMEOUT_CYCLES, 255, memory-wait limit; used only with the optional feature.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue execution; sampled in IDLE.
- halt  in  1  stop after the current instruction retires; sampled in WB.
- opcode  in  5  inst[6:2] from the instruction register.
- ctrl_addr  in  UADDR_W  control-store address from the decoder.
- mem_ack  in  1  memory completion strobe, one cycle.
- mem_req  out  1  memory request.
- mem_sel  out  1  0 = instruction address (pc), 1 = data address (ALU).
- mem_we  out  1  write strobe, stores only.
- ir_en  out  1  load instruction register from memory rdata.
- pc_en  out  1  update pc with next-pc.
- rf_we  out  1  register-file write enable.
- uaddr  out  UADDR_W  latched control-store address.
- state_o  out  3  current state encoding.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory timeout flag; constant 0 without the optional feature.
- instret  out  CNT_WIDTH  retired instruction count.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Moore outputs decoded from registered state.
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE; uaddr=0; instret=0; illegal=0; bus_err=0.
  - All strobes (mem_req, mem_we, ir_en, pc_en, rf_we) = 0.
- IDLE: go to FETCH when run=1, else stay.
- FETCH:
  - mem_req=1, mem_sel=0, mem_we=0.
  - ir_en = mem_ack, i.e. pulses in the ack cycle.
  - mem_ack=1 -> DECODE; otherwise hold with mem_req high.
- DECODE: one cycle; register-file read and decoder settle; no strobes.
  - Legal opcodes: 01100, 00100, 00000, 01000, 11000, 01101, 00101, 11001, 11011.
  - Any other opcode -> TRAP; set illegal.
- EXEC:
  - One cycle; uaddr <= ctrl_addr captured at end of EXEC, so branch flags br_eq/br_lt are final.
  - uaddr holds until the next EXEC.
  - Opcode 00000 or 01000 -> MEM, else -> WB.
- MEM:
  - mem_req=1, mem_sel=1, mem_we=1 only for opcode 01000.
  - mem_ack=1 -> WB; otherwise hold.
- WB: one cycle.
  - pc_en=1; instret increments (wraps to 0 from all-ones).
  - rf_we=1 unless opcode is 01000 or 11000.
  - Next state: halt=1 -> IDLE, else FETCH.
- TRAP: all strobes 0; held until reset; illegal/bus_err remain set.
- mem_ack outside FETCH/MEM is ignored and causes no state change.
- mem_ack in the same cycle mem_req first asserts is accepted, giving zero wait states.
- Minimum instruction latency:
  - 4 cycles for non-memory ops (FETCH, DECODE, EXEC, WB).
  - 5 cycles for load/store.
- run deasserted mid-instruction has no effect; only halt in WB stops execution.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle mem_ack=0.
  - When it reaches TIMEOUT_CYCLES: go to TRAP, bus_err=1, mem_req drops next cycle.
  - The counter resets asynchronously to 0.
- Disabled: no counter; FETCH/MEM wait indefinitely; bus_err tied 0.

Test Plan:
- ADDI (opcode 00100), zero-wait ack, run=1 -> states 1,2,3,5; rf_we=1 and pc_en=1 in WB; instret 0->1.
- LW (00000), ack delayed 3 cycles in MEM -> mem_sel=1, mem_we=0, mem_req high 4 cycles; rf_we=1 in WB; 8 cycles fetch-to-WB with zero-wait fetch.
- SW (01000) then BEQ (11000) with ctrl_addr=27 in EXEC -> store MEM has mem_we=1; rf_we=0 in both WBs; uaddr=27 after BEQ EXEC.
- Opcode 11111 -> DECODE->TRAP; illegal=1; no further mem_req; recovery only via rst_n low, which returns IDLE with instret=0.
- halt=1 during WB of 2nd instruction -> IDLE, instret=2; run=1 resumes FETCH next cycle; force instret to all-ones then retire once -> wraps to 0.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no ack in FETCH -> TRAP after 8 wait cycles; bus_err=1; rst_n asserted mid-wait clears everything immediately.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sharing one memory port between fetch and load/store.
// Optional memory-wait timeout enabled with `define MEM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read, ir loads on mem_ack
// DECODE | register read and decoder settle, illegal opcode check
// EXEC   | ALU/branch compare, control-store address captured
// MEM    | load/store data access
// WB     | register write, pc update, retire
// TRAP   | illegal opcode or bus timeout, held until reset
module multicycle_sequencer #(
    parameter int CNT_WIDTH      = 32,
    parameter int UADDR_W        = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 halt,
    input  logic [4:0]           opcode,
    input  logic [UADDR_W-1:0]   ctrl_addr,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_sel,
    output logic                 mem_we,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic                 rf_we,
    output logic [UADDR_W-1:0]   uaddr,
    output logic [2:0]           state_o,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    state_t state, state_nxt;
    logic   legal;
    logic   is_mem_op;
    logic   timeout;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
            5'b01101, 5'b00101, 5'b11001, 5'b11011: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          in_wait;

    assign in_wait = (state == S_FETCH) || (state == S_MEM);

    // Down-counter reloaded outside the wait states; terminal count is the last allowed wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (!in_wait)
            wait_cnt <= TW'(TIMEOUT_CYCLES);
        else if (!mem_ack && (wait_cnt != '0))
            wait_cnt <= wait_cnt - TW'(1);
    end

    assign timeout = in_wait && !mem_ack && (wait_cnt == TW'(1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_sel   = 1'b0;
        mem_we    = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        rf_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                ir_en   = mem_ack;
                if (mem_ack)
                    state_nxt = S_DECODE;
                else if (timeout)
                    state_nxt = S_TRAP;
            end
            S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
            S_EXEC:   state_nxt = is_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ack)
                    state_nxt = S_WB;
                else if (timeout)
                    state_nxt = S_TRAP;
            end
            S_WB: begin
                pc_en     = 1'b1;
                rf_we     = !((opcode == OP_STORE) || (opcode == OP_BRANCH));
                state_nxt = halt ? S_IDLE : S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // uaddr is taken at the end of EXEC so the branch compare flags feeding the decoder are final.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uaddr   <= '0;
            instret <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (state == S_EXEC)
                uaddr <= ctrl_addr;
            if (state == S_WB)
                instret <= instret + CNT_WIDTH'(1);
            if ((state == S_DECODE) && !legal)
                illegal <= 1'b1;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: vector table plus hand-written corner sequences.
// A narrow retired counter keeps the wrap test short.
module tb_multicycle_sequencer;

    localparam int CW = 4;
    localparam int UW = 6;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          halt;
    logic [4:0]    opcode;
    logic [UW-1:0] ctrl_addr;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_sel;
    logic          mem_we;
    logic          ir_en;
    logic          pc_en;
    logic          rf_we;
    logic [UW-1:0] uaddr;
    logic [2:0]    state_o;
    logic          illegal;
    logic          bus_err;
    logic [CW-1:0] instret;

    int tests  = 0;
    int failed = 0;

    multicycle_sequencer #(
        .CNT_WIDTH(CW),
        .UADDR_W(UW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .halt(halt),
        .opcode(opcode),
        .ctrl_addr(ctrl_addr),
        .mem_ack(mem_ack),
        .mem_req(mem_req),
        .mem_sel(mem_sel),
        .mem_we(mem_we),
        .ir_en(ir_en),
        .pc_en(pc_en),
        .rf_we(rf_we),
        .uaddr(uaddr),
        .state_o(state_o),
        .illegal(illegal),
        .bus_err(bus_err),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          run;
        logic          halt;
        logic [4:0]    op;
        logic [UW-1:0] ca;
        logic          ack;
        logic [2:0]    st;
        logic          req;
        logic          sel;
        logic          we;
        logic          ir;
        logic          pc;
        logic          rf;
        logic [UW-1:0] ua;
        logic [CW-1:0] ic;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(input logic r, input logic h, input logic [4:0] op,
                                input logic [UW-1:0] ca, input logic ack,
                                input logic [2:0] st, input logic req, input logic sel,
                                input logic we, input logic ir, input logic pc, input logic rf,
                                input logic [UW-1:0] ua, input logic [CW-1:0] ic);
        vec_t v;
        v.run = r;  v.halt = h; v.op = op; v.ca = ca; v.ack = ack;
        v.st = st;  v.req = req; v.sel = sel; v.we = we; v.ir = ir;
        v.pc = pc;  v.rf = rf;  v.ua = ua; v.ic = ic;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic h, input logic [4:0] op,
                       input logic [UW-1:0] ca, input logic ack);
        run = r; halt = h; opcode = op; ctrl_addr = ca; mem_ack = ack;
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH: zero-wait fetch, decode, exec, writeback.
    task automatic alu_instr(input logic [4:0] op, input logic halt_wb);
        cyc(1'b0, 1'b0, op, '0, 1'b1);
        cyc(1'b0, 1'b0, op, '0, 1'b0);
        cyc(1'b0, 1'b0, op, '0, 1'b0);
        cyc(1'b0, halt_wb, op, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0; halt = 1'b0; opcode = '0; ctrl_addr = '0; mem_ack = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            run h  op        ca  ack  st req sel we ir pc rf  ua  ic
        vecs[0]  = mk(1, 0, 5'b00100, 0,  0,   0, 0, 0, 0, 0, 0, 0,  0,  0);
        vecs[1]  = mk(0, 0, 5'b00100, 0,  1,   1, 1, 0, 0, 1, 0, 0,  0,  0);
        vecs[2]  = mk(0, 0, 5'b00100, 0,  0,   2, 0, 0, 0, 0, 0, 0,  0,  0);
        vecs[3]  = mk(0, 0, 5'b00100, 5,  0,   3, 0, 0, 0, 0, 0, 0,  0,  0);
        vecs[4]  = mk(0, 0, 5'b00100, 0,  0,   5, 0, 0, 0, 0, 1, 1,  5,  0);
        vecs[5]  = mk(0, 0, 5'b00000, 0,  1,   1, 1, 0, 0, 1, 0, 0,  5,  1);
        vecs[6]  = mk(0, 0, 5'b00000, 0,  0,   2, 0, 0, 0, 0, 0, 0,  5,  1);
        vecs[7]  = mk(0, 0, 5'b00000, 9,  0,   3, 0, 0, 0, 0, 0, 0,  5,  1);
        vecs[8]  = mk(0, 0, 5'b00000, 0,  0,   4, 1, 1, 0, 0, 0, 0,  9,  1);
        vecs[9]  = mk(0, 0, 5'b00000, 0,  0,   4, 1, 1, 0, 0, 0, 0,  9,  1);
        vecs[10] = mk(0, 0, 5'b00000, 0,  0,   4, 1, 1, 0, 0, 0, 0,  9,  1);
        vecs[11] = mk(0, 0, 5'b00000, 0,  1,   4, 1, 1, 0, 0, 0, 0,  9,  1);
        vecs[12] = mk(0, 0, 5'b00000, 0,  0,   5, 0, 0, 0, 0, 1, 1,  9,  1);
        vecs[13] = mk(0, 0, 5'b01000, 0,  0,   1, 1, 0, 0, 0, 0, 0,  9,  2);
        vecs[14] = mk(0, 0, 5'b01000, 0,  1,   1, 1, 0, 0, 1, 0, 0,  9,  2);
        vecs[15] = mk(0, 0, 5'b01000, 0,  1,   2, 0, 0, 0, 0, 0, 0,  9,  2);
        vecs[16] = mk(0, 0, 5'b01000, 12, 1,   3, 0, 0, 0, 0, 0, 0,  9,  2);
        vecs[17] = mk(0, 0, 5'b01000, 0,  1,   4, 1, 1, 1, 0, 0, 0, 12,  2);
        vecs[18] = mk(0, 0, 5'b01000, 0,  0,   5, 0, 0, 0, 0, 1, 0, 12,  2);
        vecs[19] = mk(0, 0, 5'b11000, 0,  1,   1, 1, 0, 0, 1, 0, 0, 12,  3);
        vecs[20] = mk(0, 0, 5'b11000, 0,  0,   2, 0, 0, 0, 0, 0, 0, 12,  3);
        vecs[21] = mk(0, 0, 5'b11000, 27, 0,   3, 0, 0, 0, 0, 0, 0, 12,  3);
        vecs[22] = mk(0, 1, 5'b11000, 0,  0,   5, 0, 0, 0, 0, 1, 0, 27,  3);
        vecs[23] = mk(0, 0, 5'b11000, 0,  1,   0, 0, 0, 0, 0, 0, 0, 27,  4);
        vecs[24] = mk(0, 0, 5'b11000, 0,  0,   0, 0, 0, 0, 0, 0, 0, 27,  4);

        rst_n = 1'b0;
        run = 1'b0; halt = 1'b0; opcode = '0; ctrl_addr = '0; mem_ack = 1'b0;
        #3;
        chk("reset state", 32'(state_o), 32'd0);
        chk("reset strobes", 32'({mem_req, mem_we, ir_en, pc_en, rf_we}), 32'd0);
        chk("reset uaddr", 32'(uaddr), 32'd0);
        chk("reset instret", 32'(instret), 32'd0);
        chk("reset flags", 32'({illegal, bus_err}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADDI, LW with 3 wait states, SW with a fetch wait, BEQ with halt.
        for (int i = 0; i < 25; i++) begin
            run = vecs[i].run; halt = vecs[i].halt; opcode = vecs[i].op;
            ctrl_addr = vecs[i].ca; mem_ack = vecs[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d outputs", i),
                32'({state_o, mem_req, mem_sel, mem_we, ir_en, pc_en, rf_we}),
                32'({vecs[i].st, vecs[i].req, vecs[i].sel, vecs[i].we,
                     vecs[i].ir, vecs[i].pc, vecs[i].rf}));
            chk($sformatf("vec%0d uaddr", i), 32'(uaddr), 32'(vecs[i].ua));
            chk($sformatf("vec%0d instret", i), 32'(instret), 32'(vecs[i].ic));
            @(posedge clk);
            #1;
        end

        // halt ignored outside WB, honoured in WB of the second instruction, run resumes.
        do_reset();
        cyc(1'b1, 1'b0, 5'b00100, '0, 1'b0);
        cyc(1'b0, 1'b1, 5'b00100, '0, 1'b1);
        cyc(1'b0, 1'b1, 5'b00100, '0, 1'b0);
        cyc(1'b0, 1'b1, 5'b00100, '0, 1'b0);
        cyc(1'b0, 1'b0, 5'b00100, '0, 1'b0);
        chk("halt first wb state", 32'(state_o), 32'd1);
        chk("halt first instret", 32'(instret), 32'd1);
        alu_instr(5'b01100, 1'b1);
        chk("halt idle state", 32'(state_o), 32'd0);
        chk("halt instret", 32'(instret), 32'd2);
        cyc(1'b1, 1'b0, 5'b00100, '0, 1'b0);
        chk("resume fetch", 32'(state_o), 32'd1);

        // Retired counter wraps from all-ones.
        do_reset();
        cyc(1'b1, 1'b0, 5'b00100, '0, 1'b0);
        for (int i = 0; i < 15; i++) alu_instr(5'b00101, 1'b0);
        chk("instret all ones", 32'(instret), 32'd15);
        alu_instr(5'b00101, 1'b0);
        chk("instret wrap", 32'(instret), 32'd0);
        chk("wrap state", 32'(state_o), 32'd1);

        // Illegal opcode traps; only reset recovers.
        do_reset();
        cyc(1'b1, 1'b0, 5'b00100, '0, 1'b0);
        alu_instr(5'b11011, 1'b0);
        cyc(1'b0, 1'b0, 5'b11111, '0, 1'b1);
        chk("illegal decode state", 32'(state_o), 32'd2);
        cyc(1'b0, 1'b0, 5'b11111, '0, 1'b0);
        chk("trap state", 32'(state_o), 32'd7);
        chk("illegal set", 32'(illegal), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 5'b00100, '0, 1'b1);
            chk($sformatf("trap hold %0d", i), 32'({state_o, mem_req, illegal}), 32'({3'd7, 1'b0, 1'b1}));
        end
        chk("trap instret", 32'(instret), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("trap reset state", 32'(state_o), 32'd0);
        chk("trap reset instret", 32'(instret), 32'd0);
        chk("trap reset illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef MEM_TIMEOUT_EN
        do_reset();
        cyc(1'b1, 1'b0, 5'b00100, '0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 5'b00100, '0, 1'b0);
            chk($sformatf("timeout wait %0d", i), 32'({state_o, mem_req, bus_err}), 32'({3'd1, 1'b1, 1'b0}));
        end
        cyc(1'b0, 1'b0, 5'b00100, '0, 1'b0);
        chk("timeout trap", 32'({state_o, mem_req, bus_err}), 32'({3'd7, 1'b0, 1'b1}));
        do_reset();
        cyc(1'b1, 1'b0, 5'b00100, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'b00100, '0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("timeout mid reset", 32'({state_o, mem_req, bus_err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`else
        do_reset();
        cyc(1'b1, 1'b0, 5'b00100, '0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 5'b00100, '0, 1'b0);
        chk("long wait holds", 32'({state_o, mem_req, bus_err}), 32'({3'd1, 1'b1, 1'b0}));
        cyc(1'b0, 1'b0, 5'b00100, '0, 1'b1);
        chk("long wait ack", 32'(state_o), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
